// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and FSM encoding for divided-clock checkers
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } div_state_e;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_LOCK_CNT    = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_ERR_W       = 8;
    localparam int MIN_RATIO       = 2;

endpackage

// File: rtl/div_clk_monitor_if.sv
// rtl/div_clk_monitor_if.sv - stimulus and measurement bundle of the divided-clock monitor
interface div_clk_monitor_if
    import div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int ERR_W = DEF_ERR_W
);
    logic             div_clk_i;
    logic [CNT_W-1:0] exp_period_i;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             meas_valid_o;
    logic             locked_o;
    logic             err_o;
    logic [ERR_W-1:0] err_cnt_o;

    modport master (
        output div_clk_i, exp_period_i,
        input  period_o, high_o, meas_valid_o, locked_o, err_o, err_cnt_o
    );

    modport slave (
        input  div_clk_i, exp_period_i,
        output period_o, high_o, meas_valid_o, locked_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/div_edge_sync.sv
// rtl/div_edge_sync.sv - optional synchronizer plus rise/fall detection of a sampled clock
module div_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);
    logic w_s;
    logic r_s_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = i_d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= i_d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign o_s    = w_s;
    assign o_rise = w_s & ~r_s_d;
    assign o_fall = ~w_s & r_s_d;
endmodule

// File: rtl/div_clk_monitor.sv
// rtl/div_clk_monitor.sv - measures period/high time of a divided clock and tracks lock
module div_clk_monitor
    import div_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int LOCK_CNT    = DEF_LOCK_CNT,
    parameter int ERR_W       = DEF_ERR_W
) (
    input  logic clk,
    input  logic rst,
    div_clk_monitor_if.slave mon
);
    localparam int               GW      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_EXP = CNT_W'(MIN_RATIO);
    localparam logic [GW-1:0]    LAST_GOOD = GW'(LOCK_CNT - 1);

    logic w_s, w_rise, w_fall;

    logic [CNT_W-1:0] r_per_cnt, r_hi_cnt, r_hi_len;
    div_state_e       r_state, w_state_nxt;
    logic [GW-1:0]    r_good_cnt, w_good_cnt_nxt;

    logic [CNT_W-1:0] r_period, r_high;
    logic             r_meas, r_err, r_locked;
    logic [ERR_W-1:0] r_err_cnt;

    logic             w_exp_ok, w_good, w_timeout, w_active;
    logic             w_meas, w_err;
    logic [CNT_W-1:0] w_half_lo, w_half_hi;
    logic [CNT_W:0]   w_exp_p1, w_twice;

    div_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .i_d   (mon.div_clk_i),
        .o_s   (w_s),
        .o_rise(w_rise),
        .o_fall(w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_hi_len  <= '0;
        end else begin
            if (w_rise) begin
                r_per_cnt <= CNT_W'(1);
            end else if (r_per_cnt != CNT_MAX) begin
                r_per_cnt <= r_per_cnt + CNT_W'(1);
            end

            if (w_rise) begin
                r_hi_cnt <= CNT_W'(1);
            end else if (w_s && r_hi_cnt != CNT_MAX) begin
                r_hi_cnt <= r_hi_cnt + CNT_W'(1);
            end

            if (w_fall) begin
                r_hi_len <= r_hi_cnt;
            end
        end
    end

    // Odd ratios accept either floor or ceil of N/2 as the high length.
    assign w_exp_p1  = {1'b0, mon.exp_period_i} + (CNT_W+1)'(1);
    assign w_half_lo = mon.exp_period_i >> 1;
    assign w_half_hi = w_exp_p1[CNT_W:1];
    assign w_twice   = {mon.exp_period_i, 1'b0};

    assign w_exp_ok  = (mon.exp_period_i >= MIN_EXP);
    assign w_good    = (r_per_cnt == mon.exp_period_i) &&
                       ((r_hi_len == w_half_lo) || (r_hi_len == w_half_hi));
    assign w_timeout = ({1'b0, r_per_cnt} == w_twice) && !w_rise;
    assign w_active  = (r_state == ST_ACQ) || (r_state == ST_LOCK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_exp_ok && w_rise) w_state_nxt = ST_ACQ;
            end
            ST_ACQ: begin
                if (w_rise) begin
                    if (w_good && r_good_cnt == LAST_GOOD) w_state_nxt = ST_LOCK;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (w_rise) begin
                    if (!w_good) w_state_nxt = ST_ACQ;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_meas         = w_rise && w_active;
        w_err          = (w_meas && !w_good) || (w_timeout && w_active);
        w_good_cnt_nxt = r_good_cnt;
        if (w_meas) begin
            if (!w_good) begin
                w_good_cnt_nxt = '0;
            end else if (r_state == ST_ACQ) begin
                w_good_cnt_nxt = r_good_cnt + GW'(1);
            end
        end else if (w_timeout && w_active) begin
            w_good_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_good_cnt <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_meas     <= 1'b0;
            r_err      <= 1'b0;
            r_locked   <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_good_cnt <= w_good_cnt_nxt;
            r_meas     <= w_meas;
            r_err      <= w_err;
            r_locked   <= (w_state_nxt == ST_LOCK);
            if (w_meas) begin
                r_period <= r_per_cnt;
                r_high   <= r_hi_len;
            end
            if (w_err && r_err_cnt != ERR_MAX) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
        end
    end

    assign mon.period_o     = r_period;
    assign mon.high_o       = r_high;
    assign mon.meas_valid_o = r_meas;
    assign mon.locked_o     = r_locked;
    assign mon.err_o        = r_err;
    assign mon.err_cnt_o    = r_err_cnt;
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb/tb_div_clk_monitor.sv - directed self-checking bench for div_clk_monitor
module tb_div_clk_monitor;
    import div_pkg::*;

    localparam int CNT_W = 8;
    localparam int ERR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_clk_monitor_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) mif ();

    div_clk_monitor #(
        .CNT_W(CNT_W), .SYNC_STAGES(2), .LOCK_CNT(4), .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mon(mif)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int n_meas, n_err, n_unlock, lock_at, err_tick, hold_start;
    int tick_n = 0;
    bit prev_lock = 1'b0;
    int per_q[$];
    int hi_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_obs();
        n_meas = 0; n_err = 0; n_unlock = 0; lock_at = 0; err_tick = -1;
        per_q.delete();
        hi_q.delete();
    endtask

    // One source-clock cycle: drive after the edge, observe on the falling edge.
    task automatic tick(input logic v);
        mif.div_clk_i = v;
        @(negedge clk);
        if (mif.meas_valid_o === 1'b1) begin
            n_meas++;
            per_q.push_back(int'(mif.period_o));
            hi_q.push_back(int'(mif.high_o));
        end
        if (mif.err_o === 1'b1) begin
            n_err++;
            if (err_tick < 0) err_tick = tick_n;
        end
        if (mif.locked_o === 1'b1 && !prev_lock) lock_at = n_meas;
        if (mif.locked_o !== 1'b1 && prev_lock) n_unlock++;
        prev_lock = (mif.locked_o === 1'b1);
        tick_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int p, input int h);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < p; j++)
                tick(j < h);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, mif.period_o, 0);
        check({tag, "_high"}, mif.high_o, 0);
        check({tag, "_meas"}, mif.meas_valid_o, 0);
        check({tag, "_locked"}, mif.locked_o, 0);
        check({tag, "_err"}, mif.err_o, 0);
        check({tag, "_errcnt"}, mif.err_cnt_o, 0);
        check({tag, "_state"}, dut.r_state, ST_IDLE);
    endtask

    initial begin
        mif.div_clk_i = 1'b0;
        mif.exp_period_i = 8'd5;
        @(posedge clk);
        #1;
        do_reset();
        check_zero("rst");

        // Divide-by-5, 40% duty
        clear_obs();
        run(8, 5, 2);
        check("d5_nmeas", n_meas, 7);
        check("d5_lock_at", lock_at, 4);
        check("d5_locked", mif.locked_o, 1);
        check("d5_nerr", n_err, 0);
        check("d5_errcnt", mif.err_cnt_o, 0);
        for (int i = 0; i < per_q.size(); i++) begin
            check("d5_period", per_q[i], 5);
            check("d5_high", hi_q[i], 2);
        end

        // Divide-by-4 then a ratio change while locked
        mif.exp_period_i = 8'd4;
        do_reset();
        clear_obs();
        run(6, 4, 2);
        check("d4_nmeas", n_meas, 5);
        check("d4_lock_at", lock_at, 4);
        check("d4_period", per_q[4], 4);
        check("d4_high", hi_q[4], 2);
        check("d4_locked", mif.locked_o, 1);
        mif.exp_period_i = 8'd6;
        clear_obs();
        run(1, 4, 2);
        check("chg_nerr", n_err, 1);
        check("chg_nmeas", n_meas, 1);
        check("chg_period", per_q[0], 4);
        check("chg_locked", mif.locked_o, 0);
        check("chg_errcnt", mif.err_cnt_o, 1);
        check("chg_state", dut.r_state, ST_ACQ);

        // Glitch inside a low phase while locked
        mif.exp_period_i = 8'd5;
        do_reset();
        clear_obs();
        run(6, 5, 2);
        check("gl_pre_locked", mif.locked_o, 1);
        check("gl_pre_lock_at", lock_at, 4);
        clear_obs();
        tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
        run(5, 5, 2);
        check("gl_nmeas", per_q.size(), 7);
        check("gl_per0", per_q[0], 5);
        check("gl_per1", per_q[1], 3);
        check("gl_hi1", hi_q[1], 2);
        check("gl_per2", per_q[2], 2);
        check("gl_hi2", hi_q[2], 1);
        check("gl_nerr", n_err, 2);
        check("gl_unlock", n_unlock, 1);
        check("gl_relock_at", lock_at, 7);
        check("gl_locked", mif.locked_o, 1);
        check("gl_errcnt", mif.err_cnt_o, 2);

        // Stopped clock while locked: timeout at per_cnt == 10
        clear_obs();
        hold_start = tick_n;
        repeat (20) tick(1'b0);
        check("to_seen", err_tick >= 0, 1);
        check("to_offset", err_tick - hold_start, 8);
        check("to_nerr", n_err, 1);
        check("to_nmeas", n_meas, 0);
        check("to_locked", mif.locked_o, 0);
        check("to_unlock", n_unlock, 1);
        check("to_errcnt", mif.err_cnt_o, 3);
        check("to_state", dut.r_state, ST_IDLE);

        clear_obs();
        run(1, 5, 2);
        check("arm_nmeas", n_meas, 0);
        check("arm_state", dut.r_state, ST_ACQ);
        run(5, 5, 2);
        check("re_nmeas", n_meas, 5);
        check("re_lock_at", lock_at, 4);
        check("re_locked", mif.locked_o, 1);
        check("re_errcnt", mif.err_cnt_o, 3);

        // Reset while locked with errors logged
        rst = 1'b1;
        tick(1'b0);
        check_zero("mid_rst");
        rst = 1'b0;
        clear_obs();
        run(8, 5, 3);
        check("post_nmeas", n_meas, 7);
        check("post_lock_at", lock_at, 4);
        check("post_high", hi_q[6], 3);
        check("post_period", per_q[6], 5);
        check("post_nerr", n_err, 0);

        // Illegal ratio keeps the block idle
        mif.exp_period_i = 8'd1;
        do_reset();
        clear_obs();
        run(6, 5, 2);
        check("ill_nmeas", n_meas, 0);
        check("ill_nerr", n_err, 0);
        check("ill_locked", mif.locked_o, 0);
        check("ill_errcnt", mif.err_cnt_o, 0);
        check("ill_state", dut.r_state, ST_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/div_clk_monitor.md
Name: div_clk_monitor

Overview:
- Downstream checker for the odd/even clock-divider outputs. It samples a divided clock on the source clock and measures its period and high time in source-clock cycles.
- Compares each measurement against a programmed expected ratio and reports lock, per-period measurements, and error events.
- Used in bring-up and in the divider testbenches as a self-checking sink for div_clk.

Parameters:
- CNT_W, 8: width of period/high counters and exp_period_i.
- SYNC_STAGES, 2: input synchronizer depth. Legal values are 0 and 2. 0 means div_clk is already synchronous to clk.
- LOCK_CNT, 4: consecutive good periods required to assert locked_o.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  source clock; every flop in the block is clocked on its rising edge.
- rst  in  1  synchronous, active-high reset.
- div_clk_i  in  1  divided clock under test.
- exp_period_i  in  CNT_W  expected period in clk cycles. Values 0 and 1 are illegal.
- period_o  out  CNT_W  last measured rise-to-rise distance.
- high_o  out  CNT_W  last measured high-phase length.
- meas_valid_o  out  1  one-cycle pulse when period_o updates.
- locked_o  out  1  LOCK_CNT consecutive good periods seen.
- err_o  out  1  one-cycle pulse on a bad period or a timeout.
- err_cnt_o  out  ERR_W  saturating count of err_o pulses.

Behaviour:
- Reset values: all outputs 0, all counters 0, FSM in IDLE, synchronizer flops 0.
- Synchronizer output: s is the last synchronizer stage; s_d is s delayed one clk.
  - rise = s & ~s_d; fall = ~s & s_d.
  - With SYNC_STAGES=2, a div_clk_i edge is seen as rise/fall 2 cycles later.
- Period counter per_cnt:
  - On rise, per_cnt <= 1.
  - Otherwise per_cnt <= per_cnt+1, saturating at all-ones.
  - Result: the value held at a rise equals the number of clk cycles since the previous rise.
- High counter hi_cnt:
  - On rise, hi_cnt <= 1.
  - Else if s=1, hi_cnt <= hi_cnt+1, saturating.
  - On fall, hi_cnt is captured into a high-length holding register (hi_len).
- Good-period rule: good = (per_cnt == exp_period_i) && (hi_len == exp_period_i>>1 || hi_len == (exp_period_i+1)>>1). Odd ratios therefore accept either floor or ceil of N/2.
- Timeout: asserted when per_cnt == 2*exp_period_i, compared at CNT_W+1 bits, without a rise.
- FSM states:
  - IDLE: wait for the first rise; period_o is not updated. If exp_period_i < 2, stay in IDLE and ignore all edges.
  - ACQ: on each rise, set period_o <= per_cnt and high_o <= hi_len, and pulse meas_valid_o.
    - If good, increment good_cnt; when good_cnt reaches LOCK_CNT, go to LOCK and assert locked_o in the same cycle.
    - If not good, pulse err_o and clear good_cnt.
  - LOCK: on each rise, update period_o/high_o and pulse meas_valid_o.
    - If not good, pulse err_o, drop locked_o, clear good_cnt, go to ACQ.
- Timeout in ACQ or LOCK: pulse err_o, drop locked_o, clear good_cnt, go to IDLE.
- The first rise after IDLE only arms the block; the first comparison happens at the second rise.
- Simultaneous events: rise and timeout in the same cycle: rise wins and the timeout is ignored.
- A rise and a fall cannot coincide, because both derive from one sampled bit.
- err_cnt_o increments on every err_o pulse and saturates at all-ones. Only rst clears it.
- exp_period_i changed mid-run takes effect at the next rise or timeout check. There is no extra flush.
- Reset asserted mid-operation returns everything to reset values on the next clk edge, including synchronizer flops and err_cnt_o.
- Output latency: period_o, high_o, meas_valid_o, err_o and locked_o are all registered, one cycle after the rise cycle.

Decomposition:
- Shared package div_pkg holds:
  - the FSM state encoding (IDLE=2'd0, ACQ=2'd1, LOCK=2'd2);
  - the default CNT_W, LOCK_CNT and SYNC_STAGES constants;
  - a helper constant for the legal minimum ratio (2).
- One sub-module is natural: div_edge_sync, covering the synchronizer, s_d, and rise/fall generation. It is reusable by other divider checkers.
- Counters, compare logic and FSM stay in div_clk_monitor.

Test Plan:
- Divide-by-5 stream, exp_period_i=5, SYNC_STAGES=2 -> every meas_valid_o has period_o=5 and high_o of 2 or 3. locked_o rises at the 5th rise after reset (1 arm + 4 good). err_cnt_o stays 0.
- Divide-by-4, 50% duty, exp_period_i=4 -> period_o=4, high_o=2, lock after 4 good periods. Then set exp_period_i=6 -> next rise gives err_o pulse, locked_o=0, FSM in ACQ, err_cnt_o=1.
- Locked divide-by-5, then a single 1-cycle glitch high inside a low phase -> period_o=3 (or per glitch position) with err_o. Re-lock after 4 clean periods.
- Locked divide-by-5, then hold div_clk_i low -> err_o exactly at per_cnt=10, FSM in IDLE, locked_o=0. Restart the clock -> first rise only arms, no meas_valid_o.
- exp_period_i=1 with an active divide-by-5 input -> FSM stays IDLE, no meas_valid_o, no err_o.
- Assert rst while locked with err_cnt_o=3 -> one cycle later all outputs are 0. After release, lock is reacquired on the same rise count as the first test.
